sccpu_run_ctrl: RTL and testbench
=================================

// Module: sccpu_run_ctrl
// PURPOSE
//   Sequencer for the single-cycle CPU (sccomp). Loads instruction memory over a ready/valid word
//   stream while holding the CPU in reset, then runs or single-steps it by clock enable. Dumps the
//   register file through the CPU's reg_sel/reg_data debug port. Replaces $readmemh loading on hardware.
// PARAMETERS
//   IM_AW   7   instruction-memory word-address width (capacity 2**IM_AW words)
//   NREG    32  registers swept by DUMP (reg_sel 0..NREG-1)
// PORTS
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   cmd_valid   in   1      command offered
//   cmd_ready   out  1      command accepted when cmd_valid&&cmd_ready
//   cmd_op      in   2      00 LOAD, 01 RUN, 10 STEP, 11 DUMP
//   cmd_arg     in   32     LOAD: word count N; RUN: cycle count N; ignored for STEP/DUMP
//   stop        in   1      aborts RUN
//   ld_valid    in   1      load word offered
//   ld_ready    out  1      load word accepted on ld_valid&&ld_ready
//   ld_data     in   32     instruction word
//   im_we       out  1      IM write strobe
//   im_addr     out  IM_AW  IM word address
//   im_wdata    out  32     IM write data
//   cpu_rst     out  1      active-high reset to CPU
//   cpu_ce      out  1      CPU clock enable
//   reg_sel     out  5      register select to CPU debug port
//   reg_data    in   32     register value from CPU (combinational in reg_sel)
//   dump_valid  out  1      dump word valid
//   dump_ready  in   1      dump word consumed on dump_valid&&dump_ready
//   dump_data   out  32     register value
//   dump_last   out  1      marks register NREG-1
//   busy        out  1      state != IDLE
//   done        out  1      one-cycle pulse on every return to IDLE
// BEHAVIOUR
//   Reset values:
//   - state=IDLE; cpu_rst=1; cpu_ce=0; im_we=0; im_addr=0; im_wdata=0; reg_sel=0.
//   - dump_valid=0; dump_last=0; dump_data=0; done=0; busy=0.
//   Mid-operation rst aborts any command immediately with the same values.
//   Registered outputs, except: cmd_ready=(state==IDLE); ld_ready=(state==LOAD); busy=!cmd_ready.
//   FSM: IDLE -> LOAD|RUN|STEP|DUMP on command accept; each returns to IDLE; done pulses for
//     exactly the first cycle back in IDLE.
//   LOAD:
//   - cpu_rst=1, cpu_ce=0 throughout; count Nc=min(N,2**IM_AW).
//   - Word k accepted in cycle t: im_we=1, im_addr=k, im_wdata=ld_data in cycle t+1.
//   - Next word may be accepted in cycle t+1 (1 word/cycle). Exit after Nc-th accept.
//   - N=0: no writes, done next cycle. Words beyond Nc are not accepted (ld_ready=0).
//   - cpu_rst stays 1 after LOAD until next RUN/STEP.
//   RUN:
//   - cpu_rst<=0 on accept; cpu_ce=1 for exactly N consecutive cycles starting the cycle after accept.
//   - stop seen in cycle t: cpu_ce=0 from t+1, IDLE.
//   - N=0: no ce cycles. N counter 32-bit, no wrap.
//   STEP: cpu_rst<=0; cpu_ce=1 for exactly one cycle (cycle after accept), then IDLE.
//   DUMP:
//   - cpu_ce=0 throughout (CPU frozen).
//   - For k=0..NREG-1: drive reg_sel=k one cycle, then capture reg_data into dump_data,
//     dump_valid=1, dump_last=(k==NREG-1).
//   - Hold until dump_ready; on handshake dump_valid=0 and reg_sel=k+1.
//   - After last handshake reg_sel returns to 0, IDLE.
//   - dump_data must not change while dump_valid=1 && !dump_ready.
//   cpu_rst is asserted only by rst or LOAD; RUN/STEP after a prior RUN continue from the current PC.
// TESTING
//   1. rst pulse mid-LOAD (after 2 of 4 words) -> cpu_rst=1, im_we=0, im_addr=0, busy=0 next cycle.
//   2. LOAD N=3, words 0x20080005,0x20090007,0x01095020 back-to-back -> im_we 3 cycles,
//      addr 0,1,2; done 1 cycle after the third.
//   3. LOAD N=200, IM_AW=7 -> exactly 128 words accepted, ld_ready=0 afterward, done pulses.
//   4. RUN N=10 -> cpu_ce high exactly 10 cycles, cpu_rst=0. RUN N=100 with stop at cycle 5 ->
//      ce high 5 cycles. RUN N=0 -> zero ce.
//   5. STEP x3 after LOAD -> three single ce pulses; CPU PC advances 0x0->0xC.
//   6. DUMP with dump_ready toggling 1/0 -> 32 words, reg_sel order 0..31, dump_data stable
//      under stall, dump_last only on word 31 (r10=0xC after test 2 program).

Source files
------------

// File: rtl/sccpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sccpu_run_ctrl
// Purpose  : Run-control sequencer for the single-cycle CPU. Streams words
//            into instruction memory while the CPU is held in reset, runs or
//            single-steps the CPU through its clock enable, and dumps the
//            register file through the CPU debug port.
// Revision : 1.0 - initial release
// ============================================================================
module sccpu_run_ctrl #(
  parameter int IM_AW = 7,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_arg,
  input  logic             stop,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_data,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [31:0]      dump_data,
  output logic             dump_last,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;

  // DUMP is split into a select phase (reg_sel settles for one cycle) and an
  // output phase (word held until the consumer takes it).
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_STEP = 3'd3;
  localparam logic [2:0] S_DSEL = 3'd4;
  localparam logic [2:0] S_DOUT = 3'd5;

  localparam logic [31:0] IM_DEPTH = 32'(1 << IM_AW);
  localparam logic [4:0]  LAST_SEL = 5'(NREG - 1);

  logic [2:0]       state_q, state_d;
  logic [IM_AW:0]   nc_q, nc_d;          // words to load, already clipped to IM size
  logic [IM_AW:0]   ld_idx_q, ld_idx_d;  // index of the next word to accept
  logic [31:0]      run_cnt_q, run_cnt_d;// remaining ce cycles after the current one
  logic             cpu_rst_q, cpu_rst_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             im_we_q, im_we_d;
  logic [IM_AW-1:0] im_addr_q, im_addr_d;
  logic [31:0]      im_wdata_q, im_wdata_d;
  logic [4:0]       reg_sel_q, reg_sel_d;
  logic             dump_valid_q, dump_valid_d;
  logic [31:0]      dump_data_q, dump_data_d;
  logic             dump_last_q, dump_last_d;
  logic             done_q, done_d;

  logic             cmd_fire;
  logic             ld_fire;
  logic             arg_zero;
  logic [IM_AW:0]   arg_clip;

  assign cmd_ready = (state_q == S_IDLE);
  assign ld_ready  = (state_q == S_LOAD);
  assign busy      = !cmd_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ld_fire   = ld_valid && ld_ready;
  assign arg_zero  = (cmd_arg == 32'd0);
  assign arg_clip  = (cmd_arg > IM_DEPTH) ? IM_DEPTH[IM_AW:0] : cmd_arg[IM_AW:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; zero-length LOAD/RUN never leave IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_LOAD: state_d = arg_zero ? S_IDLE : S_LOAD;
            OP_RUN:  state_d = arg_zero ? S_IDLE : S_RUN;
            OP_STEP: state_d = S_STEP;
            default: state_d = S_DSEL;
          endcase
        end
      end
      S_LOAD: if (ld_fire && ((ld_idx_q + 1'b1) == nc_q)) state_d = S_IDLE;
      S_RUN:  if (stop || (run_cnt_q == 32'd0)) state_d = S_IDLE;
      S_STEP: state_d = S_IDLE;
      S_DSEL: state_d = S_DOUT;
      S_DOUT: if (dump_ready) state_d = dump_last_q ? S_IDLE : S_DSEL;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values for every registered output
  always_comb begin
    nc_d         = nc_q;
    ld_idx_d     = ld_idx_q;
    run_cnt_d    = run_cnt_q;
    cpu_rst_d    = cpu_rst_q;
    cpu_ce_d     = 1'b0;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    reg_sel_d    = reg_sel_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_last_d  = dump_last_q;
    // A command accepted in IDLE that does not leave IDLE also completes.
    done_d       = ((state_q != S_IDLE) || cmd_fire) && (state_d == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_LOAD: begin
              cpu_rst_d = 1'b1;
              nc_d      = arg_clip;
              ld_idx_d  = '0;
            end
            OP_RUN: begin
              cpu_rst_d = 1'b0;
              cpu_ce_d  = !arg_zero;
              run_cnt_d = cmd_arg - 32'd1;
            end
            OP_STEP: begin
              cpu_rst_d = 1'b0;
              cpu_ce_d  = 1'b1;
            end
            default: reg_sel_d = '0;
          endcase
        end
      end
      S_LOAD: begin
        if (ld_fire) begin
          im_we_d    = 1'b1;
          im_addr_d  = ld_idx_q[IM_AW-1:0];
          im_wdata_d = ld_data;
          ld_idx_d   = ld_idx_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!stop && (run_cnt_q != 32'd0)) begin
          cpu_ce_d  = 1'b1;
          run_cnt_d = run_cnt_q - 32'd1;
        end
      end
      S_DSEL: begin
        dump_valid_d = 1'b1;
        dump_data_d  = reg_data;
        dump_last_d  = (reg_sel_q == LAST_SEL);
      end
      S_DOUT: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          dump_last_d  = 1'b0;
          reg_sel_d    = dump_last_q ? 5'd0 : (reg_sel_q + 5'd1);
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and counters; rst aborts everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nc_q         <= '0;
      ld_idx_q     <= '0;
      run_cnt_q    <= '0;
      cpu_rst_q    <= 1'b1;
      cpu_ce_q     <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      reg_sel_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      nc_q         <= nc_d;
      ld_idx_q     <= ld_idx_d;
      run_cnt_q    <= run_cnt_d;
      cpu_rst_q    <= cpu_rst_d;
      cpu_ce_q     <= cpu_ce_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      reg_sel_q    <= reg_sel_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_last_q  <= dump_last_d;
      done_q       <= done_d;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign cpu_ce     = cpu_ce_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign reg_sel    = reg_sel_q;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sccpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccpu_run_ctrl
// Purpose  : Self-checking bench for sccpu_run_ctrl with a tiny CPU stub
//            (PC, addi/add, register file) attached to the control outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sccpu_run_ctrl;

  localparam int IM_AW = 7;
  localparam int IM_DEPTH = 1 << IM_AW;
  localparam int NREG = 32;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_DUMP = 2'b11;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 0, cmd_ready, stop = 0, ld_valid = 0, ld_ready;
  logic [1:0] cmd_op = 0;
  logic [31:0] cmd_arg = 0, ld_data = 0, im_wdata, reg_data, dump_data;
  logic im_we, cpu_rst, cpu_ce, dump_valid, dump_ready = 0, dump_last, busy, done;
  logic [IM_AW-1:0] im_addr;
  logic [4:0] reg_sel;

  int n_checks = 0, n_fail = 0;

  sccpu_run_ctrl #(.IM_AW(IM_AW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .stop(stop), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .reg_sel(reg_sel),
    .reg_data(reg_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_last(dump_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // CPU stub: IM written by the controller, executes addi/add, PC += 4 per ce
  logic [31:0] im_mem [0:IM_DEPTH-1];
  logic [31:0] rf [0:31];
  logic [31:0] pc;
  logic [31:0] instr;
  assign instr    = im_mem[pc[IM_AW+1:2]];
  assign reg_data = rf[reg_sel];

  always @(posedge clk) begin
    if (im_we) im_mem[im_addr] <= im_wdata;
    if (cpu_rst) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (cpu_ce) begin
      if (instr[31:26] == 6'h08 && instr[20:16] != 5'd0)
        rf[instr[20:16]] <= rf[instr[25:21]] + {{16{instr[15]}}, instr[15:0]};
      else if (instr[31:26] == 6'h00 && instr[5:0] == 6'h20 && instr[15:11] != 5'd0)
        rf[instr[15:11]] <= rf[instr[25:21]] + rf[instr[20:16]];
      pc <= pc + 32'd4;
    end
  end

  logic [31:0] ld_words [0:255];
  logic [31:0] dumped [0:31];
  logic [31:0] exp_rf [0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for IDLE, offer one command, return one cycle after accept
  task automatic issue_cmd(input logic [1:0] op, input logic [31:0] arg);
    int w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    check("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 0;
  endtask

  // LOAD of n words from ld_words with random gaps; checks each IM write
  task automatic do_load(input int n, input int gap_pct, output int acc, output int we_cnt,
                         output int done_cnt);
    int cyc = 0;
    int nc = (n > IM_DEPTH) ? IM_DEPTH : n;
    acc = 0; we_cnt = 0; done_cnt = 0;
    issue_cmd(OP_LOAD, n);
    while (cyc < 4 * n + 40) begin
      check("load_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      if (im_we) begin
        check("load_im_addr", {25'd0, im_addr}, we_cnt);
        check("load_im_wdata", im_wdata, ld_words[we_cnt]);
        we_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (nc > 0) check("load_done_with_last_we", {31'd0, im_we}, 32'd1);
        break;
      end
      ld_valid = (acc < n) && ($urandom_range(99) >= gap_pct);
      ld_data  = ld_words[acc];
      if (ld_valid && ld_ready) begin
        tick(); acc++;
      end else tick();
      cyc++;
    end
    ld_valid = 0;
    check("load_done_seen", done_cnt, 1);
    check("load_accepted", acc, nc);
    tick();
    check("load_ld_ready_after", {31'd0, ld_ready}, 32'd0);
    for (int i = 0; i < nc; i++) check("load_im_content", im_mem[i], ld_words[i]);
  endtask

  // RUN/STEP: count ce cycles until done; stop raised during the stop_after-th ce cycle
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] arg, input int stop_after,
                         output int ce_cnt, output int done_cnt);
    int cyc = 0;
    ce_cnt = 0; done_cnt = 0;
    issue_cmd(op, arg);
    while (cyc < 300) begin
      if (cpu_ce) ce_cnt++;
      if (done) begin done_cnt++; break; end
      check("run_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
      if (stop_after > 0 && ce_cnt == stop_after) stop = 1;
      tick(); cyc++;
    end
    stop = 0;
  endtask

  // DUMP with consumer back-pressure; mode 0 toggles ready, mode 1 random
  task automatic do_dump(input int mode, output int nwords);
    int cyc = 0, tog = 0, done_cnt = 0;
    logic stall_prev = 0;
    logic [31:0] prev = 0;
    nwords = 0;
    for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
    issue_cmd(OP_DUMP, $urandom);
    while (cyc < 400) begin
      check("dump_cpu_ce_low", {31'd0, cpu_ce}, 32'd0);
      if (stall_prev) begin
        check("dump_hold_valid", {31'd0, dump_valid}, 32'd1);
        check("dump_hold_data", dump_data, prev);
      end
      if (done) begin done_cnt++; break; end
      dump_ready = (mode == 0) ? tog[0] : 1'($urandom_range(1));
      tog++;
      if (dump_valid) check("dump_reg_sel", {27'd0, reg_sel}, nwords);
      if (dump_valid && dump_ready && nwords < 32) begin
        check("dump_data", dump_data, exp_rf[nwords]);
        check("dump_last", {31'd0, dump_last}, (nwords == NREG - 1) ? 32'd1 : 32'd0);
        dumped[nwords] = dump_data;
        nwords++;
      end
      stall_prev = dump_valid && !dump_ready;
      prev = dump_data;
      tick(); cyc++;
    end
    dump_ready = 0;
    check("dump_done_seen", done_cnt, 1);
    check("dump_words", nwords, NREG);
    check("dump_reg_sel_back", {27'd0, reg_sel}, 32'd0);
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] arg;
    int          stop_after;
    int          exp_ce;
    logic [31:0] exp_pc;
  } run_vec_t;

  run_vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, we_cnt, done_cnt, ce_cnt, nw, n, s, exp_ce;
    logic [31:0] pc_model;

    vecs[0] = '{OP_STEP, 32'hDEAD, 0, 1, 32'd4};
    vecs[1] = '{OP_STEP, 32'h0,    0, 1, 32'd8};
    vecs[2] = '{OP_STEP, 32'h7,    0, 1, 32'd12};
    vecs[3] = '{OP_RUN,  32'd10,   0, 10, 32'd52};
    vecs[4] = '{OP_RUN,  32'd100,  5, 5, 32'd72};
    vecs[5] = '{OP_RUN,  32'd0,    0, 0, 32'd72};
    vecs[6] = '{OP_RUN,  32'd1,    0, 1, 32'd76};
    vecs[7] = '{OP_STEP, 32'd0,    0, 1, 32'd80};

    // Reset state
    tick(); tick();
    rst = 0;
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    check("rst_im_we", {31'd0, im_we}, 32'd0);
    check("rst_im_addr", {25'd0, im_addr}, 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_reg_sel", {27'd0, reg_sel}, 32'd0);
    check("rst_dump", {29'd0, dump_valid, dump_last, done}, 32'd0);
    check("rst_dump_data", dump_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);

    // Reset in the middle of a 4-word LOAD, after two words
    issue_cmd(OP_LOAD, 32'd4);
    ld_valid = 1; ld_data = 32'h11111111; tick();
    ld_data = 32'h22222222; tick();
    ld_valid = 0;
    check("midload_second_we", {31'd0, im_we}, 32'd1);
    rst = 1; #1;
    check("midload_rst_async", {29'd0, cpu_rst, im_we, busy}, 32'b100);
    tick();
    check("midload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("midload_im_we", {31'd0, im_we}, 32'd0);
    check("midload_im_addr", {25'd0, im_addr}, 32'd0);
    check("midload_busy", {31'd0, busy}, 32'd0);
    check("midload_done", {31'd0, done}, 32'd0);
    rst = 0; tick();

    // Three-instruction program back to back
    ld_words[0] = 32'h20080005; ld_words[1] = 32'h20090007; ld_words[2] = 32'h01095020;
    do_load(3, 0, acc, we_cnt, done_cnt);
    check("prog_we_count", we_cnt, 3);

    // Table of RUN/STEP commands
    for (int v = 0; v < 8; v++) begin
      run_cmd(vecs[v].op, vecs[v].arg, vecs[v].stop_after, ce_cnt, done_cnt);
      check("tbl_ce_cycles", ce_cnt, vecs[v].exp_ce);
      check("tbl_done", done_cnt, 1);
      check("tbl_ce_off", {31'd0, cpu_ce}, 32'd0);
      check("tbl_pc", pc, vecs[v].exp_pc);
    end

    // Register dump with alternating back-pressure
    do_dump(0, nw);
    check("dump_r8", dumped[8], 32'd5);
    check("dump_r9", dumped[9], 32'd7);
    check("dump_r10", dumped[10], 32'hC);

    // Oversized LOAD clipped to IM capacity
    for (int i = 0; i < 256; i++) ld_words[i] = $urandom;
    do_load(200, 0, acc, we_cnt, done_cnt);
    check("big_load_writes", we_cnt, IM_DEPTH);
    check("big_load_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    pc_model = 0;

    // Random command mix against the arithmetic model
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(3))
        0: begin
          n = $urandom_range(12);
          for (int i = 0; i < 16; i++) ld_words[i] = $urandom;
          do_load(n, 30, acc, we_cnt, done_cnt);
          check("rnd_load_writes", we_cnt, n);
          pc_model = 0;
        end
        1: begin
          n = $urandom_range(30);
          s = (n > 0 && $urandom_range(1) == 1) ? $urandom_range(n, 1) : 0;
          exp_ce = (s > 0 && s < n) ? s : n;
          run_cmd(OP_RUN, n, s, ce_cnt, done_cnt);
          pc_model += 4 * exp_ce;
          check("rnd_run_ce", ce_cnt, exp_ce);
          check("rnd_run_done", done_cnt, 1);
          check("rnd_run_pc", pc, pc_model);
        end
        2: begin
          run_cmd(OP_STEP, $urandom, 0, ce_cnt, done_cnt);
          pc_model += 4;
          check("rnd_step_ce", ce_cnt, 1);
          check("rnd_step_pc", pc, pc_model);
        end
        default: do_dump(1, nw);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
